gpio_ports: RTL

GPIO_PORTS -- requirements
Module: gpio_ports

---
 rtl/gpio_ports_pkg.sv | 34 +++
 rtl/gpio_port.sv | 62 ++++++
 rtl/gpio_ports.sv | 100 ++++++++++
 3 files changed

// File: rtl/gpio_ports_pkg.sv
// Register map for the GPIO port block. Per-port registers come first, then
// the pin-change masks, then the shared interrupt control and flag registers.
package gpio_ports_pkg;

    localparam int REGS_PER_PORT = 3;
    localparam int PIN_OFS       = 0;
    localparam int DDR_OFS       = 1;
    localparam int PORT_OFS      = 2;

    function automatic int pin_addr(int p);
        return REGS_PER_PORT * p + PIN_OFS;
    endfunction

    function automatic int ddr_addr(int p);
        return REGS_PER_PORT * p + DDR_OFS;
    endfunction

    function automatic int port_addr(int p);
        return REGS_PER_PORT * p + PORT_OFS;
    endfunction

    function automatic int pcmsk_addr(int num_ports, int p);
        return REGS_PER_PORT * num_ports + p;
    endfunction

    function automatic int pcicr_addr(int num_ports);
        return (REGS_PER_PORT + 1) * num_ports;
    endfunction

    function automatic int pcifr_addr(int num_ports);
        return pcicr_addr(num_ports) + 1;
    endfunction

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: direction and output registers, pin-change mask, input
// synchronizer with change detection, and per-bit tri-state pin drive.
module gpio_port #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ddr_we,
    input  logic                  port_we,
    input  logic                  pin_we,
    input  logic                  pcmsk_we,
    inout  wire  [DATA_WIDTH-1:0] pins,
    output logic [DATA_WIDTH-1:0] ddr,
    output logic [DATA_WIDTH-1:0] port,
    output logic [DATA_WIDTH-1:0] pcmsk,
    output logic [DATA_WIDTH-1:0] pin_val,
    output logic                  change
);

    logic [DATA_WIDTH-1:0] sync1;
    logic [DATA_WIDTH-1:0] sync2;
    logic [DATA_WIDTH-1:0] prev;
    logic [1:0]            warm_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ddr      <= '0;
            port     <= '0;
            pcmsk    <= '0;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            warm_cnt <= 2'd3;
        end else begin
            if (ddr_we)
                ddr <= wdata;
            if (port_we)
                port <= wdata;
            else if (pin_we)
                port <= port ^ wdata;
            if (pcmsk_we)
                pcmsk <= wdata;
            sync1 <= pins;
            sync2 <= sync1;
            prev  <= sync2;
            if (warm_cnt != 2'd0)
                warm_cnt <= warm_cnt - 2'd1;
        end
    end

    assign pin_val = sync2;

    // The first sample through the synchronizer after reset compares against
    // cleared flops; hold off change detection until prev has caught up.
    assign change = (warm_cnt == 2'd0) && (|((sync2 ^ prev) & pcmsk));

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_drive
        assign pins[i] = ddr[i] ? port[i] : 1'bz;
    end

endmodule

// File: rtl/gpio_ports.sv
// Multi-port GPIO block: host bus decode, registered read buffer, pin-change
// interrupt control/flag registers and the registered irq output.
module gpio_ports
    import gpio_ports_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cs,
    input  logic                            we,
    input  logic                            oe,
    input  logic [ADDR_WIDTH-1:0]           address,
    inout  wire  [DATA_WIDTH-1:0]           data,
    inout  wire  [NUM_PORTS*DATA_WIDTH-1:0] pins,
    output logic                            irq
);

    logic                  wr;
    logic                  rd;
    logic [31:0]           addr_ext;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] rd_buf;
    logic [NUM_PORTS-1:0]  pcicr;
    logic [NUM_PORTS-1:0]  pcifr;
    logic [NUM_PORTS-1:0]  pcifr_clr;
    logic [NUM_PORTS-1:0]  change;

    logic [DATA_WIDTH-1:0] ddr_q   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] port_q  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] pcmsk_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0] pin_val [NUM_PORTS];

    assign wr       = cs && we;
    assign rd       = cs && !we;
    assign addr_ext = 32'(address);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        gpio_port #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_port (
            .clk      (clk),
            .reset    (reset),
            .wdata    (data),
            .ddr_we   (wr && addr_ext == 32'(ddr_addr(p))),
            .port_we  (wr && addr_ext == 32'(port_addr(p))),
            .pin_we   (wr && addr_ext == 32'(pin_addr(p))),
            .pcmsk_we (wr && addr_ext == 32'(pcmsk_addr(NUM_PORTS, p))),
            .pins     (pins[p*DATA_WIDTH +: DATA_WIDTH]),
            .ddr      (ddr_q[p]),
            .port     (port_q[p]),
            .pcmsk    (pcmsk_q[p]),
            .pin_val  (pin_val[p]),
            .change   (change[p])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (addr_ext == 32'(pin_addr(p)))
                rd_mux = pin_val[p];
            if (addr_ext == 32'(ddr_addr(p)))
                rd_mux = ddr_q[p];
            if (addr_ext == 32'(port_addr(p)))
                rd_mux = port_q[p];
            if (addr_ext == 32'(pcmsk_addr(NUM_PORTS, p)))
                rd_mux = pcmsk_q[p];
        end
        if (addr_ext == 32'(pcicr_addr(NUM_PORTS)))
            rd_mux = DATA_WIDTH'(pcicr);
        if (addr_ext == 32'(pcifr_addr(NUM_PORTS)))
            rd_mux = DATA_WIDTH'(pcifr);
    end

    assign pcifr_clr = (wr && addr_ext == 32'(pcifr_addr(NUM_PORTS))) ?
                       data[NUM_PORTS-1:0] : '0;

    // A new change event wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_buf <= '0;
            pcicr  <= '0;
            pcifr  <= '0;
            irq    <= 1'b0;
        end else begin
            if (rd)
                rd_buf <= rd_mux;
            if (wr && addr_ext == 32'(pcicr_addr(NUM_PORTS)))
                pcicr <= data[NUM_PORTS-1:0];
            pcifr <= (pcifr & ~pcifr_clr) | change;
            irq   <= |(pcifr & pcicr);
        end
    end

    assign data = (cs && oe && !we) ? rd_buf : 'z;

endmodule
